// File: rtl/deck_builder.sv
// Writes a 52-card deck into card RAM as a singly linked list and reports its head.
// Define DECK_BUILDER_VERIFY_EN to add a read-back pass that flags mismatches on `error`.
module deck_builder #(
  parameter logic [9:0] BASE_ADDR = 10'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ram_q,
  output logic [9:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic [9:0]  head_addr,
  output logic [5:0]  card_count,
  output logic        error
);

  localparam logic [9:0] LAST_ADDR = BASE_ADDR + 10'd51;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_VFINAL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  ram_address_q, ram_address_d;
  logic [31:0] ram_data_q, ram_data_d;
  logic        ram_wren_q, ram_wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  head_addr_q, head_addr_d;
  logic [5:0]  card_count_q, card_count_d;

  logic [1:0]  cur_suit, nxt_suit;
  logic [3:0]  cur_value, nxt_value;
  logic [9:0]  nxt_addr;

  function automatic logic [31:0] card_word(input logic [1:0] suit,
                                            input logic [3:0] value,
                                            input logic [9:0] addr);
    logic [9:0] next_ptr;
    next_ptr = (addr == LAST_ADDR) ? 10'd0 : addr + 10'd1;
    return {16'd0, suit, value, next_ptr};
  endfunction

  // The word currently on ram_data doubles as the suit/value counter state.
  assign cur_suit  = ram_data_q[15:14];
  assign cur_value = ram_data_q[13:10];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    nxt_addr  = ram_address_q + 10'd1;
    nxt_suit  = cur_suit;
    nxt_value = cur_value + 4'd1;
    if (cur_value == 4'd13) begin
      nxt_value = 4'd1;
      nxt_suit  = cur_suit + 2'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    head_addr_d   = head_addr_q;
    card_count_d  = card_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_WRITE;
          ram_address_d = BASE_ADDR;
          ram_data_d    = card_word(2'd0, 4'd1, BASE_ADDR);
          ram_wren_d    = 1'b1;
          busy_d        = 1'b1;
          head_addr_d   = 10'd0;
          card_count_d  = 6'd0;
        end
      end
      S_WRITE: begin
        card_count_d = card_count_q + 6'd1;
        if (ram_address_q == LAST_ADDR) begin
`ifdef DECK_BUILDER_VERIFY_EN
          state_d       = S_VERIFY;
          ram_address_d = BASE_ADDR;
          ram_data_d    = card_word(2'd0, 4'd1, BASE_ADDR);
`else
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          head_addr_d = BASE_ADDR;
`endif
        end else begin
          ram_address_d = nxt_addr;
          ram_data_d    = card_word(nxt_suit, nxt_value, nxt_addr);
          ram_wren_d    = 1'b1;
        end
      end
`ifdef DECK_BUILDER_VERIFY_EN
      S_VERIFY: begin
        if (ram_address_q == LAST_ADDR) begin
          state_d = S_VFINAL;
        end else begin
          ram_address_d = nxt_addr;
          ram_data_d    = card_word(nxt_suit, nxt_value, nxt_addr);
        end
      end
      // One extra cycle to compare the read data of the last card.
      S_VFINAL: begin
        state_d     = S_DONE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        head_addr_d = BASE_ADDR;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ram_address_q <= 10'd0;
      ram_data_q    <= 32'd0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      head_addr_q   <= 10'd0;
      card_count_q  <= 6'd0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      head_addr_q   <= head_addr_d;
      card_count_q  <= card_count_d;
    end
  end

`ifdef DECK_BUILDER_VERIFY_EN
  // ram_data_q holds the expected word for the address being read; delay it to meet ram_q.
  logic [31:0] exp_q, exp_d;
  logic        cmp_valid_q, cmp_valid_d;
  logic        error_q, error_d;

  always_comb begin
    exp_d       = ram_data_q;
    cmp_valid_d = (state_q == S_VERIFY);
    error_d     = error_q;
    if (state_q == S_IDLE && start) begin
      error_d = 1'b0;
    end else if (cmp_valid_q && (ram_q != exp_q)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q       <= 32'd0;
      cmp_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      exp_q       <= exp_d;
      cmp_valid_q <= cmp_valid_d;
      error_q     <= error_d;
    end
  end

  assign error = error_q;
`else
  logic unused_ram_q;
  assign unused_ram_q = ^ram_q;
  assign error        = 1'b0;
`endif

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign head_addr   = head_addr_q;
  assign card_count  = card_count_q;

endmodule

// File: doc/deck_builder.md
# deck_builder

Builds a complete 52-card deck in card RAM as a singly linked list, the format the card-walking logic (nth-card selection and removal) consumes. After a `start` pulse it writes one card word per clock into an external `ram1024x32` port, then reports the list head address. It sits directly upstream of the dealing stages and owns the RAM write port only while `busy`.

## Interface
- `BASE_ADDR`, default 10'd1: address of the first card (head). Must be nonzero, and BASE_ADDR+51 ≤ 1023.
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `start`  in  1  begin a build; sampled only in IDLE.
- `ram_q`  in  32  RAM read data, valid the cycle after the address is presented (used only with verify).
- `ram_address`  out  10  RAM address.
- `ram_data`  out  32  RAM write word.
- `ram_wren`  out  1  RAM write enable.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `head_addr`  out  10  list head; equals BASE_ADDR when valid, otherwise 0.
- `card_count`  out  6  number of cards written so far (0..52).
- `error`  out  1  verify mismatch flag. Sticky; cleared on `start`. Tied 0 when verify is compiled out.

## Operation
- Card word format:
  - [31:16] = 0
  - [15:14] = suit
  - [13:10] = value (1..13)
  - [9:0] = next pointer; 0 means end of list.
- Card k (k = 0..51) is stored at BASE_ADDR+k with suit = k/13 and value = (k mod 13)+1.
- Next pointer is BASE_ADDR+k+1 for every card except card 51, whose next pointer is 0.
- States:
  - IDLE: `start`=1 → WRITE with k=0; `card_count` cleared to 0; `error` cleared.
  - WRITE: one word per cycle. When k=51 is written → VERIFY if compiled in, else DONE.
  - VERIFY: reads back all 52 words and compares each against the expected word → DONE.
  - DONE: `done`=1 for one cycle, `head_addr`=BASE_ADDR → IDLE.
- Suit and value come from counters (value 1..13 wrapping to 1 with a suit increment). No divide.
- `card_count` increments on each write cycle and holds 52 after completion until the next start.
- `start` while `busy` is ignored. Holding `start` high through DONE starts a new build on the next IDLE cycle.
- `ram_wren` is high only in WRITE. `ram_address`, `ram_data` and `ram_wren` are registered outputs.

## Timing
- Reset values: `ram_address`=0, `ram_data`=0, `ram_wren`=0, `busy`=0, `done`=0, `head_addr`=0, `card_count`=0, `error`=0, state IDLE.
- Start accepted at edge E. WRITE occupies cycles E+1..E+52, with `ram_address`=BASE_ADDR+k in cycle E+1+k.
- Without verify: `done` is high in cycle E+53. `busy` is high in cycles E+1..E+52.
- With verify: reads issue in cycles E+53..E+104 and compares in E+54..E+105. `done` is high in cycle E+106.
- `head_addr` becomes 0 when a start is accepted and BASE_ADDR in the `done` cycle.
- Reset mid-build: outputs take their reset values asynchronously. The partially written RAM is not cleaned up; `head_addr`=0 marks the list invalid.

## Configuration
- `DECK_BUILDER_VERIFY_EN` defined: the VERIFY state is included.
  - Any mismatching word sets `error`=1; the bench checks it in the `done` cycle.
  - `ram_wren`=0 throughout VERIFY.
- Undefined: the VERIFY state and compare logic are absent, `error` is constant 0, and `ram_q` is unused.

## Test plan
- Reset, then one `start` pulse, BASE_ADDR=1:
  - 52 consecutive writes: address 1 gets 32'h0000_0402; address 13 gets 32'h0000_340E; address 14 gets 32'h0000_440F; address 52 gets 32'h0000_F400.
  - `done` in cycle E+53; `head_addr`=1; `card_count`=52.
- BASE_ADDR=10'd100: first write {addr 100, data 32'h0000_0465}; last write address 151 with next pointer 0.
- `start` re-asserted at write k=20: ignored, no restart, write sequence unchanged, single `done`.
- `reset` asserted during write k=30: `ram_wren` drops before the next edge; `busy`=0, `card_count`=0, `head_addr`=0. A following `start` rebuilds from k=0.
- With verify defined and a RAM model:
  - Clean run → `error`=0 at `done`, cycle E+106.
  - Corrupting the word at BASE_ADDR+7 during VERIFY → `error`=1, which stays set until the next `start`.
- Back-to-back: `start` held high → second build begins the cycle after DONE+IDLE with an identical write sequence.
